wordin24_capture: RTL and testbench
===================================

Name: wordin24_capture

Overview:
- 24-bit input-side companion to the bidirectional word port.
- Samples the pin bus through a metastability synchronizer and detects rising/falling edges per bit.
- Accumulates sticky change flags, which are cleared on read.
- Raises a masked interrupt, and returns pin levels, change flags or mask on the shared tristate read bus.

Parameters:
- WIDTH, 24, number of port bits.
- SYNC_STAGES, 2, synchronizer flop count; legal range 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clear  input  1  asynchronous active-low reset; clear=0 resets immediately, release is sampled on clk.
- portdata  input  WIDTH  raw pin levels, asynchronous to clk.
- ibus  input  WIDTH  write data bus.
- obus  output  WIDTH  read data bus; high-Z when no read select is active.
- readport  input  1  drive synchronized pin levels onto obus.
- readchange  input  1  drive change flags onto obus and clear them.
- readmask  input  1  drive interrupt mask onto obus.
- loadmask  input  1  maskreg <= ibus.
- loadrise  input  1  riseen <= ibus (per-bit rising-edge enable).
- loadfall  input  1  fallen <= ibus (per-bit falling-edge enable).
- irq  output  1  registered OR of (changereg & maskreg).

Behaviour:
Reset (clear=0):
- sync chain, prev, changereg, maskreg, riseen, fallen, irq, armcnt all 0.
- obus high-Z.

Synchronizer:
- portdata passes through SYNC_STAGES flops; last stage = s.
- prev <= s every cycle.
- Pin change visible on readport data after SYNC_STAGES clk edges.

Edge detect:
- rise = s & ~prev; fall = ~s & prev.
- event = (rise & riseen) | (fall & fallen).

Arming:
- armcnt counts 0..SYNC_STAGES+1 after reset release, then holds.
- event is forced to 0 while armcnt < SYNC_STAGES+1.
- Pins already high at reset therefore produce no spurious rising event.

Change flags:
- Normal cycle: changereg <= changereg | event.
- Read cycle with readchange winning the read priority: obus shows the pre-update changereg; next state = event only. A new event in the read cycle survives and is never lost.
- Flag sets on the edge after the one where s changes, i.e. SYNC_STAGES+1 edges after the pin change.

Mask/enable registers:
- Plain load registers; load takes effect on the next edge.
- Writes of different registers in the same cycle are independent.
- readmask in the same cycle as loadmask returns the old value.

irq:
- Registered from (changereg & maskreg) != 0, so it lags the flag by one cycle.
- Deasserts one cycle after the flags are cleared by read, or after the mask bit is cleared.

Read bus:
- Combinational mux from current register values.
- Priority readport > readchange > readmask.
- Clear-on-read applies only when readchange is the winning select (readport=0).
- No select active → obus = all Z.

Reset mid-operation:
- Asynchronous clear immediately zeroes irq and the flags.
- The arming sequence restarts on release.

Test Plan:
1. Reset/arm: hold portdata=24'hFFFFFF, release clear, enable riseen=24'hFFFFFF, wait 10 cycles → changereg=0, irq=0, readport returns 24'hFFFFFF. Check obus=Z when idle.
2. Rising edge latency: riseen=24'h000001, maskreg=24'h000001; toggle bit0 0→1 → readport shows bit0 after 2 edges, flag bit0 after 3 edges, irq=1 after 4 edges. readchange returns 24'h000001; next cycle flags=0; irq=0 one cycle later.
3. Falling/both and masking: riseen=24'h00F000, fallen=24'h00F000, maskreg=0; pulse bit12 high for 5 cycles → readchange returns 24'h001000, irq stays 0. Set maskreg=24'h001000 before the read → irq=1.
4. Event during read: bit3 flag set; assert readchange in the same cycle a bit5 enabled edge is detected → obus=24'h000008; following cycle flags=24'h000020.
5. Read priority: assert readport and readchange together with flags=24'h0000F0 → obus=pin levels, flags remain 24'h0000F0. Assert readchange and readmask together → obus=flags, flags cleared.
6. Async reset mid-operation: flags=24'hABCDEF, irq=1; pulse clear low between clk edges → irq and flags 0 immediately. No event reported until armcnt completes, even if pins toggle during arming.

Source files
------------

// File: rtl/wordin24_capture.sv
// Pin-side capture for the word port: synchronizes the pins, detects per-bit edges,
// keeps sticky clear-on-read change flags, and drives a masked irq and a tristate read bus.
module wordin24_capture #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2     // 2..4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] portdata,
    input  logic [WIDTH-1:0] ibus,
    output logic [WIDTH-1:0] obus,
    input  logic             readport,
    input  logic             readchange,
    input  logic             readmask,
    input  logic             loadmask,
    input  logic             loadrise,
    input  logic             loadfall,
    output logic             irq
);

    localparam int            CW       = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_DONE = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_change;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_riseen;
    logic [WIDTH-1:0] r_fallen;
    logic [CW-1:0]    r_armcnt;
    logic             r_irq;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_armed;
    logic             w_rd_en;
    logic             w_clr_rd;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_armed  = (r_armcnt == ARM_DONE);
    // Edges seen before the chain and prev hold real pin data are artefacts of reset.
    assign w_event  = w_armed ? ((w_s & ~r_prev & r_riseen) | (~w_s & r_prev & r_fallen))
                              : '0;
    assign w_clr_rd = readchange & ~readport;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= portdata;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_s;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)        r_armcnt <= '0;
        else if (!w_armed) r_armcnt <= r_armcnt + CW'(1);
    end

    // A read clears only what was shown; an edge landing in the read cycle is kept.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)        r_change <= '0;
        else if (w_clr_rd) r_change <= w_event;
        else               r_change <= r_change | w_event;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_mask   <= '0;
            r_riseen <= '0;
            r_fallen <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (loadmask) r_mask   <= ibus;
            if (loadrise) r_riseen <= ibus;
            if (loadfall) r_fallen <= ibus;
            r_irq <= |(r_change & r_mask);
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (readport)        w_rd_data = w_s;
        else if (readchange) w_rd_data = r_change;
        else if (readmask)   w_rd_data = r_mask;
    end

    assign w_rd_en = readport | readchange | readmask;
    assign obus    = w_rd_en ? w_rd_data : {WIDTH{1'bz}};
    assign irq     = r_irq;

endmodule

// File: tb/tb_wordin24_capture.sv
// Directed bench for wordin24_capture; expectations queued by stimulus, checked by a monitor.
module tb_wordin24_capture;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [23:0] portdata = 24'hFFFFFF;
    logic [23:0] ibus = '0;
    tri1  [23:0] obus_w;
    logic        readport = 0, readchange = 0, readmask = 0;
    logic        loadmask = 0, loadrise = 0, loadfall = 0;
    logic        irq;
    logic        smp = 0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        bit          cb;
        logic [23:0] bus;
        bit          ci;
        logic        iv;
    } exp_t;
    exp_t q[$];

    wordin24_capture #(.WIDTH(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .clear(clear), .portdata(portdata), .ibus(ibus), .obus(obus_w),
        .readport(readport), .readchange(readchange), .readmask(readmask),
        .loadmask(loadmask), .loadrise(loadrise), .loadfall(loadfall), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per sampled cycle.
    always @(negedge clk) begin
        if (smp) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard_empty: sample requested with no expectation");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cb) begin
                    n_chk++;
                    if (obus_w !== e.bus) begin
                        n_fail++;
                        $display("FAIL %s: obus got %h want %h", e.name, obus_w, e.bus);
                    end
                end
                if (e.ci) begin
                    n_chk++;
                    if (irq !== e.iv) begin
                        n_fail++;
                        $display("FAIL %s: irq got %b want %b", e.name, irq, e.iv);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            readport = 0; readchange = 0; readmask = 0;
            loadmask = 0; loadrise = 0; loadfall = 0; smp = 0;
        end
    endtask

    task automatic step(input bit rp, input bit rc, input bit rm,
                        input bit cb, input logic [23:0] bus,
                        input bit ci, input logic iv, input string nm);
        exp_t e;
        readport = rp; readchange = rc; readmask = rm;
        e.name = nm; e.cb = cb; e.bus = bus; e.ci = ci; e.iv = iv;
        q.push_back(e);
        smp = 1;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset and arming with pins already high
        #2 clear = 0;
        cyc(1);
        step(0,1,0, 1,24'h000000, 1,0, "rst_flags");
        step(0,0,1, 1,24'h000000, 0,0, "rst_mask");
        clear = 1; loadrise = 1; ibus = 24'hFFFFFF;
        cyc(1);
        cyc(10);
        step(0,1,0, 1,24'h000000, 1,0, "arm_no_spurious");
        step(1,0,0, 1,24'hFFFFFF, 0,0, "arm_readport");
        step(0,0,0, 1,24'hFFFFFF, 0,0, "idle_z_1");

        // 2. rising edge latency on bit0
        loadrise = 1; loadmask = 1; ibus = 24'h000001; portdata = 24'h000000;
        cyc(1);
        cyc(4);
        step(0,1,0, 1,24'h000000, 0,0, "fall_not_enabled");
        step(0,0,0, 1,24'hFFFFFF, 0,0, "idle_z_2");
        portdata = 24'h000001;
        step(1,0,0, 1,24'h000000, 0,0, "lat_port_e0");
        step(1,0,0, 1,24'h000000, 0,0, "lat_port_e1");
        step(1,0,0, 1,24'h000001, 1,0, "lat_port_e2");
        step(0,1,0, 1,24'h000001, 1,0, "lat_flag_e3");
        step(0,1,0, 1,24'h000000, 1,1, "lat_irq_e4");
        step(0,0,0, 1,24'hFFFFFF, 1,0, "irq_clear");

        // 3. rise+fall on bit12, masked then unmasked
        loadrise = 1; loadfall = 1; ibus = 24'h00F000;
        cyc(1);
        loadmask = 1; ibus = 24'h000000;
        cyc(1);
        portdata = 24'h001001;
        cyc(5);
        portdata = 24'h000001;
        cyc(5);
        step(0,0,0, 0,24'h0, 1,0, "masked_irq_low");
        loadmask = 1; ibus = 24'h001000;
        step(0,0,0, 0,24'h0, 1,0, "mask_load_cycle");
        step(0,0,0, 0,24'h0, 1,0, "mask_irq_lag");
        step(0,1,0, 1,24'h001000, 1,1, "bit12_flag_irq");
        step(0,1,0, 1,24'h000000, 1,1, "bit12_cleared");
        step(0,0,0, 0,24'h0, 1,0, "bit12_irq_drop");

        // 4. edge detected during the clearing read
        loadrise = 1; ibus = 24'h000028;
        cyc(1);
        portdata = 24'h000009;
        cyc(4);
        portdata = 24'h000029;
        cyc(2);
        step(0,1,0, 1,24'h000008, 0,0, "read_during_event");
        step(0,1,0, 1,24'h000020, 0,0, "event_survived");
        step(0,1,0, 1,24'h000000, 0,0, "event_cleared");

        // 5. read priority and mask read/load collision
        loadrise = 1; ibus = 24'h0000F0; portdata = 24'h000001;
        cyc(1);
        cyc(4);
        step(0,1,0, 1,24'h000000, 0,0, "prio_pre_clear");
        portdata = 24'h0000F1;
        cyc(4);
        step(1,1,0, 1,24'h0000F1, 0,0, "prio_port_over_chg");
        step(0,1,1, 1,24'h0000F0, 0,0, "prio_chg_over_mask");
        step(0,1,0, 1,24'h000000, 0,0, "prio_chg_cleared");
        loadmask = 1; ibus = 24'hABCDEF;
        step(0,0,1, 1,24'h001000, 0,0, "mask_old_on_load");
        step(0,0,1, 1,24'hABCDEF, 0,0, "mask_new");

        // 6. async clear mid-operation
        portdata = 24'h000000;
        cyc(4);
        step(0,1,0, 1,24'h000000, 0,0, "pre6_clear");
        loadrise = 1; ibus = 24'hFFFFFF;
        cyc(1);
        portdata = 24'hABCDEF;
        cyc(5);
        step(0,0,1, 1,24'hABCDEF, 1,1, "pre_reset_irq");
        clear = 0; portdata = 24'h000000;
        step(0,1,0, 1,24'h000000, 1,0, "async_clear_flags");
        step(0,0,1, 1,24'h000000, 1,0, "async_clear_mask");
        clear = 1; loadrise = 1; loadmask = 1; ibus = 24'hFFFFFF; portdata = 24'hFFFFFF;
        cyc(1);
        cyc(8);
        step(0,1,0, 1,24'h000000, 1,0, "rearm_no_event");
        portdata = 24'h000000;
        cyc(4);
        portdata = 24'h000100;
        cyc(4);
        step(0,1,0, 1,24'h000100, 1,1, "post_arm_event");
        step(0,1,0, 1,24'h000000, 1,1, "post_arm_cleared");

        cyc(1);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
